// File: rtl/gc_collect_pkg.sv
// Shared types and constants for the garbler output collector.
// Contents: entry type enum, buffered entry struct, garbler tag constants,
// collector state enum. Entry field widths GC_S/GC_K set the default S/K.
package gc_collect_pkg;

  localparam int unsigned GC_S = 8;
  localparam int unsigned GC_K = 128;

  typedef enum logic [1:0] {
    LABEL = 2'd0,
    KEY   = 2'd1,
    TABLE = 2'd2,
    MASK  = 2'd3
  } entry_type_e;

  typedef struct packed {
    entry_type_e        etype;
    logic [GC_S-1:0]    cid;
    logic [GC_S-1:0]    index;
    logic [GC_K-1:0]    data;
  } gc_entry_t;

  localparam logic [2:0]  TAG_KEY       = 3'b001;
  localparam logic [2:0]  TAG_TABLE     = 3'b010;
  localparam logic [2:0]  TAG_MASK      = 3'b011;
  localparam int unsigned TAG_LABEL_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/gc_output_collector_if.sv
// Host-link entry stream (valid/ready) of the output collector.
// master: drives out_valid/out_type/out_cid/out_index/out_data, samples out_ready.
// slave:  the host side.
interface gc_output_collector_if
  import gc_collect_pkg::*;
#(
  parameter int unsigned S = GC_S,
  parameter int unsigned K = GC_K
) ();

  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_type;
  logic [S-1:0] out_cid;
  logic [S-1:0] out_index;
  logic [K-1:0] out_data;

  modport master (
    output out_valid, out_type, out_cid, out_index, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_type, out_cid, out_index, out_data,
    output out_ready
  );

endinterface

// File: rtl/gc_out_fifo.sv
// Dual-write, single-read entry FIFO. Port 0 is written before port 1 when
// both fire. Pointers carry one extra wrap bit (modulo 2*DEPTH).
// Ports: clk, rst, clear_i (sync flush), we0_i/we1_i + wdata0_i/wdata1_i,
// re_i, rdata_c_o (head entry), empty_c_o, full_c_o, free_c_o (free slots).
module gc_out_fifo
  import gc_collect_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     we0_i,
  input  logic                     we1_i,
  input  gc_entry_t                wdata0_i,
  input  gc_entry_t                wdata1_i,
  input  logic                     re_i,
  output gc_entry_t                rdata_c_o,
  output logic                     empty_c_o,
  output logic                     full_c_o,
  output logic [$clog2(DEPTH):0]   free_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  gc_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr1_c, count_c;

  // Pointer arithmetic and status flags
  always_comb begin
    wptr1_c   = wptr_q + PW'(we0_i);
    wptr_d    = wptr1_c + PW'(we1_i);
    rptr_d    = rptr_q + PW'(re_i);
    count_c   = wptr_q - rptr_q;
    free_c_o  = PW'(DEPTH) - count_c;
    empty_c_o = (wptr_q == rptr_q);
    full_c_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    rdata_c_o = mem_q[rptr_q[AW-1:0]];
  end

  // Storage; second write lands just behind the first
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[wptr_q[AW-1:0]]  <= wdata0_i;
    if (we1_i) mem_q[wptr1_c[AW-1:0]] <= wdata1_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/gc_output_collector.sv
// Collects the garbler's tagged output stream, decodes each cycle into 0..2
// typed entries, buffers them and streams them to the host one per cycle.
// Ports: clk, rst (async, active high), start, tag_t1, cid, index0_t1,
// index1_t1, data0_t1, data1_t1, out_if (master entry stream), overflow
// (sticky drop flag), busy, done.
// Optional macro GC_COLLECT_STATS_EN adds n_labels, n_tables, n_masks
// counters of entries actually written. S/K must match GC_S/GC_K.
module gc_output_collector
  import gc_collect_pkg::*;
#(
  parameter int unsigned S     = GC_S,
  parameter int unsigned K     = GC_K,
  parameter int unsigned CC    = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              tag_t1,
  input  logic [S-1:0]            cid,
  input  logic [S-1:0]            index0_t1,
  input  logic [S-1:0]            index1_t1,
  input  logic [K-1:0]            data0_t1,
  input  logic [K-1:0]            data1_t1,
  gc_output_collector_if.master   out_if,
  output logic                    overflow,
  output logic                    busy,
  output logic                    done
`ifdef GC_COLLECT_STATS_EN
  ,
  output logic [2*S-1:0]          n_labels,
  output logic [2*S-1:0]          n_tables,
  output logic [S-1:0]            n_masks
`endif
);

  localparam int unsigned FW = $clog2(DEPTH) + 1;

  state_e          state_q, state_d;
  logic            collect_en_c, flush_c, busy_d, done_d;
  logic            busy_q, done_q, overflow_q, out_valid_q;
  gc_entry_t       out_q;
  gc_entry_t       ea_c, eb_c, wd0_c, wd1_c, fifo_rdata_c;
  logic            va_c, vb_c, free_ok_c, accept_c, drop_c, load_c;
  logic [1:0]      n_req_c;
  logic            fifo_empty_c, fifo_full_c;
  logic [FW-1:0]   fifo_free_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; start outside IDLE/DONE is ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_COLLECT;
      ST_COLLECT: if (cid == S'(CC)) state_d = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty_c && !out_valid_q) state_d = ST_DONE;
      ST_DONE:    if (start) state_d = ST_COLLECT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; busy/done are registered from the next state
  always_comb begin
    collect_en_c = (state_q == ST_COLLECT) && (cid != S'(CC));
    flush_c      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    busy_d       = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
    done_d       = (state_d == ST_DONE);
  end

  // Tag decode; a lone entry is always steered onto write port 0
  always_comb begin
    ea_c = '{etype: LABEL, cid: cid, index: index0_t1, data: data0_t1};
    eb_c = '{etype: LABEL, cid: cid, index: index1_t1, data: data1_t1};
    va_c = 1'b0;
    vb_c = 1'b0;
    if (tag_t1[TAG_LABEL_BIT]) begin
      va_c = tag_t1[0];
      vb_c = tag_t1[1];
    end else begin
      unique case (tag_t1)
        TAG_KEY: begin
          ea_c.etype = KEY;  ea_c.index = '0;
          eb_c.etype = KEY;  eb_c.index = GC_S'(1);
          va_c = 1'b1;       vb_c = 1'b1;
        end
        TAG_TABLE: begin
          ea_c.etype = TABLE;
          eb_c.etype = TABLE;
          va_c = 1'b1;       vb_c = 1'b1;
        end
        TAG_MASK: begin
          ea_c.etype = MASK; ea_c.index = '0;
          va_c = 1'b1;
        end
        default: ;
      endcase
    end
    wd0_c   = va_c ? ea_c : eb_c;
    wd1_c   = eb_c;
    n_req_c = 2'(va_c) + 2'(vb_c);
  end

  // Whole-cycle admission: free count is taken before any same-cycle read
  always_comb begin
    free_ok_c = !fifo_full_c && (fifo_free_c >= FW'(n_req_c));
    accept_c  = collect_en_c && (n_req_c != 2'd0) && free_ok_c;
    drop_c    = collect_en_c && (n_req_c != 2'd0) && !free_ok_c;
    load_c    = !fifo_empty_c && (!out_valid_q || out_if.out_ready);
  end

  gc_out_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (flush_c),
    .we0_i     (accept_c),
    .we1_i     (accept_c && (n_req_c == 2'd2)),
    .wdata0_i  (wd0_c),
    .wdata1_i  (wd1_c),
    .re_i      (load_c),
    .rdata_c_o (fifo_rdata_c),
    .empty_c_o (fifo_empty_c),
    .full_c_o  (fifo_full_c),
    .free_c_o  (fifo_free_c)
  );

  // Registered output stage; holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (load_c) begin
      out_valid_q <= 1'b1;
      out_q       <= fifo_rdata_c;
    end else if (out_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (flush_c)     overflow_q <= 1'b0;
      else if (drop_c) overflow_q <= 1'b1;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_type  = out_q.etype;
  assign out_if.out_cid   = out_q.cid;
  assign out_if.out_index = out_q.index;
  assign out_if.out_data  = out_q.data;
  assign overflow         = overflow_q;
  assign busy             = busy_q;
  assign done             = done_q;

`ifdef GC_COLLECT_STATS_EN
  localparam int unsigned CW = 2 * S;
  logic [CW-1:0] n_labels_q, n_tables_q;
  logic [S-1:0]  n_masks_q;

  // Counts only entries admitted to the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush_c) begin
      n_labels_q <= '0;
      n_tables_q <= '0;
      n_masks_q  <= '0;
    end else if (accept_c) begin
      if (tag_t1[TAG_LABEL_BIT])   n_labels_q <= n_labels_q + CW'(n_req_c);
      else if (tag_t1 == TAG_TABLE) n_tables_q <= n_tables_q + CW'(n_req_c);
      else if (tag_t1 == TAG_MASK)  n_masks_q  <= n_masks_q + S'(1);
    end
  end

  assign n_labels = n_labels_q;
  assign n_tables = n_tables_q;
  assign n_masks  = n_masks_q;
`endif

endmodule

// File: tb/tb_gc_output_collector.sv
// Bench for gc_output_collector: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the collector.
module tb_gc_output_collector;
  import gc_collect_pkg::*;

  localparam int unsigned S = 8, K = 128, CC = 2, DEPTH = 16;
  localparam int P_IDLE = 0, P_COL = 1, P_DRN = 2, P_DONE = 3;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   tag;
  logic [S-1:0] cid, idx0, idx1;
  logic [K-1:0] d0, d1;
  logic         overflow, busy, done;
`ifdef GC_COLLECT_STATS_EN
  logic [2*S-1:0] n_lab, n_tab;
  logic [S-1:0]   n_msk;
`endif

  gc_output_collector_if #(.S(S), .K(K)) out_if ();

  gc_output_collector #(.S(S), .K(K), .CC(CC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .tag_t1(tag), .cid(cid),
    .index0_t1(idx0), .index1_t1(idx1), .data0_t1(d0), .data1_t1(d1),
    .out_if(out_if), .overflow(overflow), .busy(busy), .done(done)
`ifdef GC_COLLECT_STATS_EN
    , .n_labels(n_lab), .n_tables(n_tab), .n_masks(n_msk)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic gc_entry_t mk(input entry_type_e t, input logic [S-1:0] c,
                                   input logic [S-1:0] i, input logic [K-1:0] d);
    gc_entry_t e;
    e.etype = t; e.cid = c; e.index = i; e.data = d;
    return e;
  endfunction

  gc_entry_t dut_e;
  always_comb dut_e = mk(entry_type_e'(out_if.out_type), out_if.out_cid, out_if.out_index, out_if.out_data);

  // Behavioural model: buffered entries, one output slot, sticky overflow, run phase
  gc_entry_t m_fifo[$];
  gc_entry_t got[$];
  gc_entry_t m_oreg;
  logic      m_ov, m_over, m_busy, m_done;
  int        m_phase;

  function automatic gc_entry_t got_at(input int i);
    if (i < got.size()) return got[i];
    return '0;
  endfunction

  always @(posedge clk) begin : model
    gc_entry_t nw[$];
    logic xfer, pop;
    int   free, nph;
    if (out_if.out_valid && out_if.out_ready) got.push_back(dut_e);
    if (rst) begin
      m_fifo.delete(); m_oreg = '0; m_ov = 0; m_over = 0;
      m_phase = P_IDLE; m_busy = 0; m_done = 0;
    end else begin
      nw.delete();
      if (m_phase == P_COL && cid != S'(CC)) begin
        if (tag[2]) begin
          if (tag[0]) nw.push_back(mk(LABEL, cid, idx0, d0));
          if (tag[1]) nw.push_back(mk(LABEL, cid, idx1, d1));
        end else if (tag == 3'b001) begin
          nw.push_back(mk(KEY, cid, S'(0), d0));
          nw.push_back(mk(KEY, cid, S'(1), d1));
        end else if (tag == 3'b010) begin
          nw.push_back(mk(TABLE, cid, idx0, d0));
          nw.push_back(mk(TABLE, cid, idx1, d1));
        end else if (tag == 3'b011) begin
          nw.push_back(mk(MASK, cid, S'(0), d0));
        end
      end
      free = DEPTH - m_fifo.size();
      xfer = m_ov && out_if.out_ready;
      pop  = (m_fifo.size() > 0) && (!m_ov || out_if.out_ready);
      nph  = m_phase;
      case (m_phase)
        P_IDLE:  if (start) nph = P_COL;
        P_COL:   if (cid == S'(CC)) nph = P_DRN;
        P_DRN:   if (m_fifo.size() == 0 && !m_ov) nph = P_DONE;
        default: if (start) nph = P_COL;
      endcase
      if (xfer) m_ov = 0;
      if (pop) begin m_oreg = m_fifo.pop_front(); m_ov = 1; end
      if (nw.size() > 0) begin
        if (free >= nw.size()) foreach (nw[i]) m_fifo.push_back(nw[i]);
        else m_over = 1;
      end
      if (start && (m_phase == P_IDLE || m_phase == P_DONE)) begin
        m_fifo.delete(); m_over = 0;
      end
      m_phase = nph;
      m_busy  = (nph == P_COL) || (nph == P_DRN);
      m_done  = (nph == P_DONE);
    end
    #1;
    chk("out_valid", 256'(out_if.out_valid), 256'(m_ov));
    if (m_ov) chk("out_entry", 256'(dut_e), 256'(m_oreg));
    chk("overflow", 256'(overflow), 256'(m_over));
    chk("busy", 256'(busy), 256'(m_busy));
    chk("done", 256'(done), 256'(m_done));
  end

  task automatic drive(input logic [2:0] t, input logic [S-1:0] c, input logic [S-1:0] i0,
                       input logic [S-1:0] i1, input logic [K-1:0] a, input logic [K-1:0] b);
    tag = t; cid = c; idx0 = i0; idx1 = i1; d0 = a; d1 = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(3'b000, cid, '0, '0, '0, '0);
  endtask

  task automatic pulse_start();
    start = 1'b1; tag = 3'b000;
    @(negedge clk);
    start = 1'b0;
  endtask

  localparam logic [K-1:0] A  = 128'hA0A0_0000_0000_0000_0000_0000_0000_00AA;
  localparam logic [K-1:0] B  = 128'hB0B0_0000_0000_0000_0000_0000_0000_00BB;
  localparam logic [K-1:0] K0 = 128'h0C0C_1111_2222_3333_4444_5555_6666_7770;
  localparam logic [K-1:0] K1 = 128'h0C0C_1111_2222_3333_4444_5555_6666_7771;
  localparam logic [K-1:0] M  = 128'h3333_DEAD_BEEF_0000_0000_0000_0000_0003;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    gc_entry_t snap;
    int t3, td;
    rst = 1'b1; start = 1'b0; tag = '0; cid = '0; idx0 = '0; idx1 = '0; d0 = '0; d1 = '0;
    out_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 256'(out_if.out_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));

    // Reset mid-run with five entries buffered
    pulse_start();
    drive(3'b101, 0, 1, 2, A, B);
    drive(3'b001, 0, 0, 0, K0, K1);
    drive(3'b010, 0, 6, 7, A, B);
    idle(1);
    chk("pre_rst_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 256'(out_if.out_valid), 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_ovf", 256'(overflow), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("post_rst_empty", 256'(out_if.out_valid), 256'(0));

    // Labels, keys, tables with the host always ready
    out_if.out_ready = 1'b1;
    pulse_start();
    got.delete();
    drive(3'b101, 0, 3, 4, A, B);
    drive(3'b110, 0, 3, 4, A, B);
    drive(3'b001, 0, 9, 9, K0, K1);
    drive(3'b010, 0, 6, 7, A, B);
    idle(4);
    chk("basic_count", 256'(got.size()), 256'(6));
    chk("label_a", 256'(got_at(0)), 256'(mk(LABEL, 0, 3, A)));
    chk("label_b", 256'(got_at(1)), 256'(mk(LABEL, 0, 4, B)));
    chk("key0", 256'(got_at(2)), 256'(mk(KEY, 0, 0, K0)));
    chk("key1", 256'(got_at(3)), 256'(mk(KEY, 0, 1, K1)));
    chk("table0", 256'(got_at(4)), 256'(mk(TABLE, 0, 6, A)));
    chk("table1", 256'(got_at(5)), 256'(mk(TABLE, 0, 7, B)));

    // Nine double-entry cycles into a stalled buffer: ninth cycle dropped whole
    out_if.out_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 9; i++)
      drive(3'b010, 0, S'(2*i), S'(2*i+1), K'(2*i), K'(2*i+1));
    idle(1);
    chk("ovf_set", 256'(overflow), 256'(1));
    out_if.out_ready = 1'b1;
    idle(20);
    chk("ovf_count", 256'(got.size()), 256'(16));
    for (int i = 0; i < 16; i++)
      chk("ovf_order", 256'(got_at(i)), 256'(mk(TABLE, 0, S'(i), K'(i))));

    // Mask entry
    got.delete();
    drive(3'b011, 1, 5, 5, M, B);
    idle(3);
    chk("mask", 256'(got_at(0)), 256'(mk(MASK, 1, 0, M)));

    // Stall: outputs hold
    out_if.out_ready = 1'b0;
    drive(3'b010, 1, 1, 2, K0, K1);
    idle(1);
    snap = dut_e;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("stall_valid", 256'(out_if.out_valid), 256'(1));
      chk("stall_hold", 256'(dut_e), 256'(snap));
    end
    out_if.out_ready = 1'b1;
    idle(4);

    // Random traffic, cid kept below CC
    for (int i = 0; i < 300; i++) begin
      out_if.out_ready = 1'($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 31) == 0);
      drive(3'($urandom), S'($urandom_range(0, 1)), S'($urandom), S'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    end
    start = 1'b0;
    out_if.out_ready = 1'b1;
    idle(40);

    // End of garbling with three entries pending
    out_if.out_ready = 1'b0;
    got.delete();
    drive(3'b010, 1, 8, 9, A, B);
    drive(3'b011, 1, 0, 0, M, B);
    drive(3'b010, S'(CC), 1, 1, K0, K1);
    tag = 3'b000;
    out_if.out_ready = 1'b1;
    t3 = -1; td = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (t3 < 0 && got.size() >= 3) t3 = c;
      if (td < 0 && done) td = c;
    end
    chk("end_done_seen", 256'(td >= 0), 256'(1));
    chk("end_done_timing", 256'(td - t3), 256'(1));
    chk("end_count", 256'(got.size()), 256'(3));
    chk("end_mask", 256'(got_at(2)), 256'(mk(MASK, 1, 0, M)));
    chk("end_busy", 256'(busy), 256'(0));
    pulse_start();
    chk("restart_done", 256'(done), 256'(0));
    chk("restart_busy", 256'(busy), 256'(1));
    idle(4);
    chk("redone", 256'(done), 256'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gc_output_collector.md
Name: gc_output_collector

Overview:
- Downstream consumer of the garbler's tagged output stream (tag_t1, cid, index0_t1/index1_t1, data0_t1/data1_t1).
- Decodes each tagged cycle into 0, 1 or 2 typed entries and buffers them in a dual-write, single-read FIFO.
- Emits entries one per cycle on a valid/ready stream to the host link.
- Flags completion once the final clock cycle of the circuit (cid==CC) has been seen and the buffer has drained.

Parameters:
- S, 8, index/cid width
- K, 128, label width
- CC, 2, number of garbled clock cycles; cid==CC marks end of garbling
- DEPTH, 16, FIFO entries, power of two, >=4

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; begins a collection run (same pulse that starts the garbler)
- tag_t1  in  3  garbler tag
- cid  in  S  current garbled cycle id
- index0_t1  in  S  index for data0
- index1_t1  in  S  index for data1
- data0_t1  in  K  first data word
- data1_t1  in  K  second data word
- out_valid  out  1  entry available
- out_ready  in  1  host accepts entry
- out_type  out  2  0 label, 1 key, 2 table, 3 mask
- out_cid  out  S  cid of entry
- out_index  out  S  index of entry
- out_data  out  K  entry data
- overflow  out  1  sticky; entries dropped
- busy  out  1  state is COLLECT or DRAIN
- done  out  1  run complete

Behaviour:
- Reset (asynchronous, rst high): all outputs 0; FIFO empty; state IDLE; FIFO pointers 0.
- States:
  - IDLE: start -> COLLECT.
  - COLLECT: cid==CC sampled -> DRAIN.
  - DRAIN: FIFO empty and no pending output -> DONE.
  - DONE: start -> COLLECT, clearing overflow, done and FIFO.
- Decode is active only in COLLECT and only while cid!=CC. In the cycle cid==CC, no entries are written.
- Decode rules:
  - tag[2]=1 (input labels): tag[0] -> entry {0,cid,index0,data0}; tag[1] -> entry {0,cid,index1,data1}.
  - tag=3'b001 (keys): entries {1,cid,0,data0}, {1,cid,1,data1}.
  - tag=3'b010 (tables): entries {2,cid,index0,data0}, {2,cid,index1,data1}.
  - tag=3'b011 (mask): entry {3,cid,0,data0}.
  - tag=3'b000: nothing.
- When two entries are produced in one cycle, the data0 entry is written first and is read first.
- Write latency: an entry written at edge N may appear on out_* at edge N+1 at the earliest (registered output stage).
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, all out_* are held stable.
  - out_valid never drops without a transfer, except on reset.
- Overflow:
  - If the FIFO free count is less than the entries required this cycle, the whole cycle's entries are dropped (no partial write) and overflow is set.
  - overflow stays set until reset or a new start.
- A read and a double write in the same cycle are allowed. Free count is evaluated before the read, so a cycle that would fit only because of the simultaneous read is treated as overflow.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full when the MSBs differ and the low bits are equal.
- done: asserted in DONE, held until start or reset.
- busy = (state==COLLECT || state==DRAIN).
- start while in COLLECT or DRAIN is ignored.

Optional Feature:
- Macro: GC_COLLECT_STATS_EN.
- Defined:
  - Adds outputs n_labels, n_tables (each 2*S bits) and n_masks (S bits).
  - Each increments per entry actually written; dropped entries are not counted.
  - All three clear on reset and on start.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package gc_collect_pkg:
  - entry_type_e enum (LABEL=0, KEY=1, TABLE=2, MASK=3).
  - Parameterised entry struct {type, cid, index, data}.
  - Tag constants TAG_KEY=3'b001, TAG_TABLE=3'b010, TAG_MASK=3'b011, TAG_LABEL_BIT=2.
- Sub-module gc_out_fifo: two write ports (we0/we1, in order), one read port, full/empty/free-count outputs, depth DEPTH.

Test Plan:
- Reset mid-run with 5 entries buffered -> next cycle out_valid=0, busy=0, overflow=0; FIFO empty after rst release.
- start, then tag=3'b101 cid=0 index0=3 index1=4 data=A/B, out_ready=1 -> exactly one label entry {0,0,3,A}; one cycle later the same tag with 3'b110 yields only {0,0,4,B}.
- tag=3'b001 data0=K0 data1=K1 -> two key entries, index 0 then 1, in order.
- tag=3'b010 index0=6 index1=7 -> two table entries in order.
- out_ready=0, feed 9 table cycles (18 entries, DEPTH=16) -> first 8 cycles stored (16 entries); 9th dropped whole; overflow=1; release ready -> exactly 16 entries out in order.
- tag=3'b011 cid=1 data0=M -> one mask entry {3,1,0,M}.
- Stall out_ready=0 for 3 cycles with out_valid=1 -> out_* stable.
- Drive cid=CC=2 with 3 entries pending -> no new writes; done rises the cycle after the 3rd transfer; busy falls with it; a new start clears done.
